// File: rtl/apb_chip_ctrl_regs.sv
// rtl/apb_chip_ctrl_regs.sv - APB chip-control registers: pad mux, FLL bypass, clock divider, scratch, lock
module apb_chip_ctrl_regs #(
    parameter int          N_PADS      = 48,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] INFO_VALUE  = 32'h5055_4C50
) (
    input  logic                  soc_clk_i,
    input  logic                  soc_rstn_synced_i,
    input  logic [31:0]           paddr_i,
    input  logic [31:0]           pwdata_i,
    input  logic                  pwrite_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic [2:0]            pprot_i,
    output logic [31:0]           prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic [2*N_PADS-1:0]   padmux_o,
    output logic                  fll_bypass_o,
    output logic [3:0]            clk_div_o,
    output logic                  clk_div_valid_o,
    output logic                  lock_o
);
    localparam int         PW       = (N_PADS > 1) ? $clog2(N_PADS) : 1;
    localparam logic [3:0] LP_WAIT  = 4'(WAIT_CYCLES);
    localparam logic [9:0] LP_NPADS = 10'(N_PADS);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_scratch;
    logic        r_fll_bypass;
    logic        r_lock;
    logic [3:0]  r_clk_div;
    logic        r_clk_div_valid;
    logic [7:0]  r_err_cnt;
    logic [1:0]  r_padmux [N_PADS];

    logic [11:0] w_off;
    logic [11:0] w_pad_off;
    logic [9:0]  w_pad_idx;
    logic        w_is_info, w_is_scratch, w_is_ctrl, w_is_status, w_is_pad;
    logic        w_mapped, w_err, w_complete, w_wr_ok;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_unused     = ^{paddr_i[31:12], pprot_i[2:1]};

    assign w_off        = paddr_i[11:0];
    assign w_pad_off    = w_off - 12'h100;
    assign w_pad_idx    = w_pad_off[11:2];
    assign w_is_info    = (w_off == 12'h000);
    assign w_is_scratch = (w_off == 12'h004);
    assign w_is_ctrl    = (w_off == 12'h008);
    assign w_is_status  = (w_off == 12'h00C);
    assign w_is_pad     = (w_off >= 12'h100) && (w_pad_idx < LP_NPADS);
    assign w_mapped     = w_is_info | w_is_scratch | w_is_ctrl | w_is_status | w_is_pad;

    // Any error suppresses the register update and zeroes read data.
    always_comb begin
        w_err = 1'b0;
        if (paddr_i[1:0] != 2'b00 || !w_mapped) begin
            w_err = 1'b1;
        end else if (pwrite_i) begin
            if (w_is_info || w_is_status)
                w_err = 1'b1;
            else if (!w_is_scratch && !pprot_i[0])
                w_err = 1'b1;
            else if ((w_is_ctrl || w_is_pad) && r_lock)
                w_err = 1'b1;
            else if (w_is_ctrl && pwdata_i[7:4] == 4'd0)
                w_err = 1'b1;
        end
    end

    assign w_complete = (r_state == S_ACCESS) && psel_i && (r_cnt == 4'd0);
    assign w_wr_ok    = w_complete && pwrite_i && !w_err;

    always_comb begin
        w_rdata = '0;
        if (w_complete && !pwrite_i && !w_err) begin
            if (w_is_info)
                w_rdata = INFO_VALUE;
            else if (w_is_scratch)
                w_rdata = r_scratch;
            else if (w_is_ctrl)
                w_rdata = {24'd0, r_clk_div, 2'b00, r_lock, r_fll_bypass};
            else if (w_is_status)
                w_rdata = {16'd0, r_err_cnt, 7'd0, r_lock};
            else if (w_is_pad)
                w_rdata = {30'd0, r_padmux[w_pad_idx[PW-1:0]]};
        end
    end

    always_ff @(posedge soc_clk_i) begin
        if (!soc_rstn_synced_i) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_scratch       <= '0;
            r_fll_bypass    <= 1'b0;
            r_lock          <= 1'b0;
            r_clk_div       <= 4'd1;
            r_clk_div_valid <= 1'b0;
            r_err_cnt       <= '0;
            for (int k = 0; k < N_PADS; k++) r_padmux[k] <= 2'b00;
        end else begin
            r_clk_div_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (psel_i && !penable_i) begin
                        r_cnt   <= LP_WAIT;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!psel_i) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= S_IDLE;
                        if (w_err && r_err_cnt != 8'hFF)
                            r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_wr_ok) begin
                if (w_is_scratch)
                    r_scratch <= pwdata_i;
                if (w_is_ctrl) begin
                    r_fll_bypass    <= pwdata_i[0];
                    r_lock          <= r_lock | pwdata_i[1];
                    r_clk_div       <= pwdata_i[7:4];
                    r_clk_div_valid <= (pwdata_i[7:4] != r_clk_div);
                end
                if (w_is_pad)
                    r_padmux[w_pad_idx[PW-1:0]] <= pwdata_i[1:0];
            end
        end
    end

    for (genvar k = 0; k < N_PADS; k++) begin : g_pad
        assign padmux_o[2*k +: 2] = r_padmux[k];
    end

    assign pready_o        = w_complete;
    assign pslverr_o       = w_complete && w_err;
    assign prdata_o        = w_rdata;
    assign fll_bypass_o    = r_fll_bypass;
    assign clk_div_o       = r_clk_div;
    assign clk_div_valid_o = r_clk_div_valid;
    assign lock_o          = r_lock;

endmodule
